segment_remover_var: RTL and testbench

SEGMENT_REMOVER_VAR -- requirements
Module: segment_remover_var

---
 rtl/segment_rmv_pkg.sv | 30 +++
 rtl/segment_remover_var_compactor.sv | 55 +++++
 rtl/segment_remover_var.sv | 244 ++++++++++++++++++++++++
 tb/tb_segment_remover_var.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/segment_rmv_pkg.sv
// Shared types and lane-count helpers for the variable segment remover.
package segment_rmv_pkg;

    localparam int unsigned LANE_BITS = 16;

    typedef enum logic [1:0] {
        ST_PRE   = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FLUSH = 2'd2,
        ST_PASS  = 2'd3
    } seg_state_e;

    typedef struct packed {
        logic [1:0]           keep;
        logic [LANE_BITS-1:0] data;
    } lane_t;

    function automatic int unsigned bus_lane_count(input int unsigned bus_width);
        return bus_width / LANE_BITS;
    endfunction

    function automatic int unsigned hold_lane_count(input int unsigned bus_width);
        return 2 * bus_lane_count(bus_width) - 1;
    endfunction

    function automatic int unsigned lane_cnt_width(input int unsigned bus_width);
        return $clog2(2 * bus_lane_count(bus_width));
    endfunction

endpackage

// File: rtl/segment_remover_var_compactor.sv
// lane_compactor: packs surviving input lanes behind the held lanes and splits
// the result into an outgoing full beat and the residue left in the holding register.
module lane_compactor
    import segment_rmv_pkg::*;
#(
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned HOLD_LANES = 7,
    parameter int unsigned CNT_W      = 3
) (
    input  lane_t [NUM_LANES-1:0]  in_lanes,
    input  logic  [NUM_LANES-1:0]  lane_mask,
    input  lane_t [HOLD_LANES-1:0] hold_lanes,
    input  logic  [CNT_W-1:0]      hold_cnt,
    output logic  [CNT_W-1:0]      total_c,
    output logic                   emit_c,
    output lane_t [NUM_LANES-1:0]  beat_lanes_c,
    output lane_t [HOLD_LANES-1:0] residue_c,
    output logic  [CNT_W-1:0]      residue_cnt_c
);

    lane_t [HOLD_LANES-1:0] packed_lanes;
    logic  [CNT_W-1:0]      idx;

    // Held lanes first, then each surviving input lane at the next free slot.
    always_comb begin
        packed_lanes = '0;
        idx          = hold_cnt;
        for (int j = 0; j < HOLD_LANES; j++) begin
            if (CNT_W'(j) < hold_cnt) packed_lanes[j] = hold_lanes[j];
        end
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_mask[i]) begin
                packed_lanes[idx] = in_lanes[i];
                idx               = idx + CNT_W'(1);
            end
        end
        total_c = idx;
    end

    assign emit_c = (total_c >= CNT_W'(NUM_LANES));

    always_comb begin
        beat_lanes_c  = packed_lanes[NUM_LANES-1:0];
        residue_c     = packed_lanes;
        residue_cnt_c = total_c;
        if (emit_c) begin
            residue_c     = '0;
            residue_cnt_c = total_c - CNT_W'(NUM_LANES);
            for (int j = 0; j < HOLD_LANES - NUM_LANES; j++) begin
                residue_c[j] = packed_lanes[j + NUM_LANES];
            end
        end
    end

endmodule

// File: rtl/segment_remover_var.sv
// AXI-Stream segment remover: deletes seg_size bytes starting at seg_offset from each packet.
// Optional statistics counters are enabled with the SEG_RMV_STATS_EN macro.
module segment_remover_var
    import segment_rmv_pkg::*;
#(
    parameter int unsigned AXIS_BUS_WIDTH   = 64,
    parameter int unsigned AXIS_TUSER_WIDTH = 4,
    parameter int unsigned MAX_REMOVE_BYTES = 8,
    parameter int unsigned MAX_OFFSET_BYTES = 64
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,
    input  logic [AXIS_BUS_WIDTH-1:0]             axis_in_tdata,
    input  logic [AXIS_BUS_WIDTH/8-1:0]           axis_in_tkeep,
    input  logic [AXIS_TUSER_WIDTH-1:0]           axis_in_tuser,
    input  logic                                  axis_in_tlast,
    input  logic                                  axis_in_tvalid,
    output logic                                  axis_in_tready,
    output logic [AXIS_BUS_WIDTH-1:0]             axis_out_tdata,
    output logic [AXIS_BUS_WIDTH/8-1:0]           axis_out_tkeep,
    output logic [AXIS_TUSER_WIDTH-1:0]           axis_out_tuser,
    output logic                                  axis_out_tlast,
    output logic                                  axis_out_tvalid,
    input  logic                                  axis_out_tready,
    input  logic [$clog2(MAX_OFFSET_BYTES+1)-1:0] seg_offset,
    input  logic [$clog2(MAX_REMOVE_BYTES+1)-1:0] seg_size,
    output logic                                  trunc_pulse
`ifdef SEG_RMV_STATS_EN
    ,
    output logic [31:0]                           stat_pkt_count,
    output logic [31:0]                           stat_rmv_bytes
`endif
);

    localparam int unsigned NUM_LANES  = bus_lane_count(AXIS_BUS_WIDTH);
    localparam int unsigned NUM_BYTES  = AXIS_BUS_WIDTH / 8;
    localparam int unsigned HOLD_LANES = hold_lane_count(AXIS_BUS_WIDTH);
    localparam int unsigned CNT_W      = lane_cnt_width(AXIS_BUS_WIDTH);
    localparam int unsigned OFF_W      = $clog2(MAX_OFFSET_BYTES + 1);
    localparam int unsigned SIZE_W     = $clog2(MAX_REMOVE_BYTES + 1);
    localparam int unsigned POS_CAP    = MAX_OFFSET_BYTES + MAX_REMOVE_BYTES;
    localparam int unsigned POS_W      = $clog2(POS_CAP + NUM_BYTES + 1);

    seg_state_e                  state_q, state_d;
    lane_t [NUM_LANES-1:0]       out_lanes_q, out_lanes_d;
    logic [AXIS_TUSER_WIDTH-1:0] out_user_q, out_user_d;
    logic                        out_last_q, out_last_d;
    logic                        out_valid_q, out_valid_d;
    logic                        trunc_q, trunc_d;
    lane_t [HOLD_LANES-1:0]      hold_q, hold_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [POS_W-1:0]            pos_q, pos_d;
    logic                        in_pkt_q, in_pkt_d;
    logic [POS_W-1:0]            off_q, off_d, size_q, size_d;
    logic [AXIS_TUSER_WIDTH-1:0] user_q, user_d;

    logic                        slot_free, accept;
    logic [POS_W-1:0]            off_eff, size_eff, seg_end, beat_end, pkt_end, lane_byte;
    lane_t [NUM_LANES-1:0]       in_lanes;
    logic [NUM_LANES-1:0]        lane_mask, lane_cut;
    logic [AXIS_TUSER_WIDTH-1:0] beat_user;
    logic [CNT_W-1:0]            total_c, residue_cnt_c;
    logic                        emit_c;
    lane_t [NUM_LANES-1:0]       beat_lanes_c;
    lane_t [HOLD_LANES-1:0]      residue_c;
    logic                        unused_seg_lsb;

    assign unused_seg_lsb = seg_offset[0] ^ seg_size[0];

    assign slot_free      = !out_valid_q || axis_out_tready;
    assign axis_in_tready = (state_q != ST_FLUSH) && slot_free;
    assign accept         = axis_in_tvalid && axis_in_tready;

    // Segment bounds are taken from the ports on a packet's first beat only.
    assign off_eff  = in_pkt_q ? off_q  : POS_W'({seg_offset[OFF_W-1:1], 1'b0});
    assign size_eff = in_pkt_q ? size_q : POS_W'({seg_size[SIZE_W-1:1], 1'b0});
    assign seg_end  = off_eff + size_eff;
    assign beat_end = pos_q + POS_W'(NUM_BYTES);

    always_comb begin
        lane_byte = pos_q;
        pkt_end   = pos_q;
        for (int i = 0; i < NUM_LANES; i++) begin
            in_lanes[i].data = axis_in_tdata[LANE_BITS*i +: LANE_BITS];
            in_lanes[i].keep = axis_in_tkeep[2*i +: 2];
            lane_byte        = pos_q + POS_W'(2*i);
            lane_cut[i]      = axis_in_tkeep[2*i] && (lane_byte >= off_eff) && (lane_byte < seg_end);
            lane_mask[i]     = axis_in_tkeep[2*i] && !lane_cut[i];
            if (axis_in_tkeep[2*i]) pkt_end = pkt_end + POS_W'(2);
        end
    end

    assign beat_user = (|lane_mask) ? axis_in_tuser : user_q;

    lane_compactor #(
        .NUM_LANES  (NUM_LANES),
        .HOLD_LANES (HOLD_LANES),
        .CNT_W      (CNT_W)
    ) u_compactor (
        .in_lanes      (in_lanes),
        .lane_mask     (lane_mask),
        .hold_lanes    (hold_q),
        .hold_cnt      (cnt_q),
        .total_c       (total_c),
        .emit_c        (emit_c),
        .beat_lanes_c  (beat_lanes_c),
        .residue_c     (residue_c),
        .residue_cnt_c (residue_cnt_c)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= ST_PRE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FLUSH: if (slot_free) state_d = ST_PRE;
            default: begin
                if (accept) begin
                    if (axis_in_tlast)
                        state_d = (emit_c && residue_cnt_c != '0) ? ST_FLUSH : ST_PRE;
                    else if (size_eff == '0)
                        state_d = ST_PASS;
                    else if (seg_end <= beat_end)
                        state_d = (residue_cnt_c == '0) ? ST_PASS : ST_SHIFT;
                    else
                        state_d = ST_PRE;
                end
            end
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q && !axis_out_tready;
        out_lanes_d = out_lanes_q;
        out_user_d  = out_user_q;
        out_last_d  = out_last_q;
        trunc_d     = 1'b0;
        hold_d      = hold_q;
        cnt_d       = cnt_q;
        pos_d       = pos_q;
        in_pkt_d    = in_pkt_q;
        off_d       = off_q;
        size_d      = size_q;
        user_d      = user_q;
        if (state_q == ST_FLUSH) begin
            if (slot_free) begin
                out_valid_d = 1'b1;
                out_lanes_d = hold_q[NUM_LANES-1:0];
                out_user_d  = user_q;
                out_last_d  = 1'b1;
                hold_d      = '0;
                cnt_d       = '0;
            end
        end else if (accept) begin
            user_d   = beat_user;
            in_pkt_d = !axis_in_tlast;
            off_d    = off_eff;
            size_d   = size_eff;
            hold_d   = residue_c;
            cnt_d    = residue_cnt_c;
            if (axis_in_tlast)                      pos_d = '0;
            else if (beat_end >= POS_W'(POS_CAP))   pos_d = POS_W'(POS_CAP);
            else                                    pos_d = beat_end;
            trunc_d = axis_in_tlast && (off_eff < pkt_end) && (pkt_end < seg_end);
            if (axis_in_tlast && !emit_c) begin
                hold_d = '0;
                cnt_d  = '0;
            end
            if (emit_c || (axis_in_tlast && total_c != '0)) begin
                out_valid_d = 1'b1;
                out_lanes_d = beat_lanes_c;
                out_user_d  = beat_user;
                out_last_d  = axis_in_tlast && !(emit_c && residue_cnt_c != '0);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid_q <= 1'b0;
            out_lanes_q <= '0;
            out_user_q  <= '0;
            out_last_q  <= 1'b0;
            trunc_q     <= 1'b0;
            hold_q      <= '0;
            cnt_q       <= '0;
            pos_q       <= '0;
            in_pkt_q    <= 1'b0;
            off_q       <= '0;
            size_q      <= '0;
            user_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_lanes_q <= out_lanes_d;
            out_user_q  <= out_user_d;
            out_last_q  <= out_last_d;
            trunc_q     <= trunc_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            pos_q       <= pos_d;
            in_pkt_q    <= in_pkt_d;
            off_q       <= off_d;
            size_q      <= size_d;
            user_q      <= user_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            axis_out_tdata[LANE_BITS*i +: LANE_BITS] = out_lanes_q[i].data;
            axis_out_tkeep[2*i +: 2]                 = out_lanes_q[i].keep;
        end
    end

    assign axis_out_tvalid = out_valid_q;
    assign axis_out_tuser  = out_user_q;
    assign axis_out_tlast  = out_last_q;
    assign trunc_pulse     = trunc_q;

`ifdef SEG_RMV_STATS_EN
    logic [CNT_W-1:0] rmv_lanes;

    always_comb begin
        rmv_lanes = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_cut[i]) rmv_lanes = rmv_lanes + CNT_W'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stat_pkt_count <= '0;
            stat_rmv_bytes <= '0;
        end else if (accept) begin
            if (axis_in_tlast) stat_pkt_count <= stat_pkt_count + 32'd1;
            stat_rmv_bytes <= stat_rmv_bytes + 32'({rmv_lanes, 1'b0});
        end
    end
`endif

endmodule

// File: tb/tb_segment_remover_var.sv
// Bench for segment_remover_var: byte-queue reference model plus directed packet vectors.
module tb_segment_remover_var;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] in_data;
    logic [7:0]  in_keep;
    logic [3:0]  in_user;
    logic        in_last, in_valid, in_ready;
    logic [63:0] out_data;
    logic [7:0]  out_keep;
    logic [3:0]  out_user;
    logic        out_last, out_valid, out_ready;
    logic [6:0]  seg_offset;
    logic [3:0]  seg_size;
    logic        trunc_pulse;
`ifdef SEG_RMV_STATS_EN
    logic [31:0] stat_pkt_count, stat_rmv_bytes;
`endif

    segment_remover_var dut (
        .aclk            (clk),
        .aresetn         (rst_n),
        .axis_in_tdata   (in_data),
        .axis_in_tkeep   (in_keep),
        .axis_in_tuser   (in_user),
        .axis_in_tlast   (in_last),
        .axis_in_tvalid  (in_valid),
        .axis_in_tready  (in_ready),
        .axis_out_tdata  (out_data),
        .axis_out_tkeep  (out_keep),
        .axis_out_tuser  (out_user),
        .axis_out_tlast  (out_last),
        .axis_out_tvalid (out_valid),
        .axis_out_tready (out_ready),
        .seg_offset      (seg_offset),
        .seg_size        (seg_size),
        .trunc_pulse     (trunc_pulse)
`ifdef SEG_RMV_STATS_EN
        ,
        .stat_pkt_count  (stat_pkt_count),
        .stat_rmv_bytes  (stat_rmv_bytes)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic [3:0]  user;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    int          errors = 0;
    int          checks = 0;
    bit          chk_en = 1'b1;
    bit          rand_ready = 1'b0;
    bit          count_tready = 1'b0;
    int          rx_beats = 0;
    logic [7:0]  rx_last_keep = '0;
    int          trunc_seen = 0;
    int          exp_trunc = 0;
    int          tready_low = 0;
    bit          prev_stall = 1'b0;
    beat_t       prev_beat = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] keep_mask(input logic [7:0] k);
        logic [63:0] m = '0;
        for (int j = 0; j < 8; j++) if (k[j]) m[8*j +: 8] = 8'hFF;
        return m;
    endfunction

    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Scoreboard: every accepted output beat is checked against the model queue.
    always @(negedge clk) begin
        beat_t cur, e;
        cur = {out_data, out_keep, out_user, out_last};
        if (rst_n && chk_en) begin
            if (prev_stall) check("hold_stable", 128'(cur), 128'(prev_beat));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 128'(cur), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data & keep_mask(e.keep), e.data);
                    check("out_keep", 128'(out_keep), 128'(e.keep));
                    check("out_user", 128'(out_user), 128'(e.user));
                    check("out_last", 128'(out_last), 128'(e.last));
                end
                rx_beats++;
                rx_last_keep = out_keep;
            end
            if (trunc_pulse) trunc_seen++;
            if (count_tready && !in_ready) tready_low++;
        end
        prev_stall = rst_n && out_valid && !out_ready;
        prev_beat  = cur;
    end

    // Model: keep bytes outside [off, off+size), repack into 8-byte beats.
    task automatic send_pkt(input int len, input int off, input int sz, input logic [3:0] ubase,
                            input int stop_after);
        logic [7:0] pkt[$];
        logic [7:0] pb[$];
        int         ps[$];
        int         offe, sze, nbeats;
        beat_t      b;
        offe   = off & ~1;
        sze    = sz & ~1;
        nbeats = (len + 7) / 8;
        for (int i = 0; i < len; i++) begin
            logic [7:0] v;
            v = 8'(i * 13 + int'(ubase) * 29 + 5);
            pkt.push_back(v);
            if (!(i >= offe && i < offe + sze)) begin
                pb.push_back(v);
                ps.push_back(i / 8);
            end
        end
        for (int k = 0; k < pb.size(); k += 8) begin
            b = '0;
            for (int j = 0; j < 8 && k + j < pb.size(); j++) begin
                b.data[8*j +: 8] = pb[k+j];
                b.keep[j]        = 1'b1;
                b.user           = 4'(int'(ubase) + ps[k+j]);
            end
            b.last = (k + 8 >= pb.size());
            exp_q.push_back(b);
        end
        if (offe < len && len < offe + sze) exp_trunc++;
        for (int bt = 0; bt < nbeats; bt++) begin
            int w;
            w = 0;
            if (stop_after != 0 && bt == stop_after) break;
            in_data = '0;
            in_keep = '0;
            for (int j = 0; j < 8 && bt * 8 + j < len; j++) begin
                in_data[8*j +: 8] = pkt[bt*8+j];
                in_keep[j]        = 1'b1;
            end
            in_user    = 4'(int'(ubase) + bt);
            in_last    = (bt == nbeats - 1);
            in_valid   = 1'b1;
            seg_offset = (bt == 0) ? 7'(off) : 7'($urandom_range(0, 64));
            seg_size   = (bt == 0) ? 4'(sz)  : 4'($urandom_range(0, 8));
            forever begin
                @(negedge clk);
                if (in_ready) break;
                w++;
                if (w > 200) begin
                    check("in_ready_timeout", 128'(in_ready), 128'(1));
                    break;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check("drain", 128'(exp_q.size()), 128'(0));
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t0;
        rst_n      = 1'b0;
        in_data    = '0;
        in_keep    = '0;
        in_user    = '0;
        in_last    = 1'b0;
        in_valid   = 1'b0;
        seg_offset = '0;
        seg_size   = '0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 128'(out_valid), 128'(0));
        check("rst_data", 128'(out_data), 128'(0));
        check("rst_keep", 128'(out_keep), 128'(0));
        check("rst_last", 128'(out_last), 128'(0));
        check("rst_user", 128'(out_user), 128'(0));
        check("rst_trunc", 128'(trunc_pulse), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Offset 12, size 4, 64 bytes: 60 bytes out.
        rx_beats = 0;
        send_pkt(64, 12, 4, 4'd1, 0);
        wait_drain();
        check("p29_beats", 128'(rx_beats), 128'(8));
        check("p29_last_keep", 128'(rx_last_keep), 128'(8'h0F));

        // Size 0 with random backpressure: unchanged.
        rx_beats   = 0;
        rand_ready = 1'b1;
        send_pkt(64, 6, 0, 4'd2, 0);
        wait_drain();
        rand_ready = 1'b0;
        check("p30_beats", 128'(rx_beats), 128'(8));
        check("p30_last_keep", 128'(rx_last_keep), 128'(8'hFF));

        // Offset 4, size 4, 16 bytes: tail beat through the flush state.
        rx_beats     = 0;
        tready_low   = 0;
        count_tready = 1'b1;
        send_pkt(16, 4, 4, 4'd3, 0);
        wait_drain();
        count_tready = 1'b0;
        check("p31_tready_low", 128'(tready_low), 128'(1));
        check("p31_beats", 128'(rx_beats), 128'(2));
        check("p31_last_keep", 128'(rx_last_keep), 128'(8'h0F));

        // Truncated inside the segment, then ending before it.
        rx_beats = 0;
        t0       = trunc_seen;
        send_pkt(14, 12, 4, 4'd4, 0);
        wait_drain();
        check("p32_trunc", 128'(trunc_seen - t0), 128'(1));
        check("p32_beats", 128'(rx_beats), 128'(2));
        check("p32_last_keep", 128'(rx_last_keep), 128'(8'h0F));
        rx_beats = 0;
        t0       = trunc_seen;
        send_pkt(10, 12, 4, 4'd5, 0);
        wait_drain();
        check("p32b_trunc", 128'(trunc_seen - t0), 128'(0));
        check("p32b_beats", 128'(rx_beats), 128'(2));
        check("p32b_last_keep", 128'(rx_last_keep), 128'(8'h03));

        // Size 0 latency is one cycle.
        send_pkt(8, 0, 0, 4'd6, 0);
        check("latency1", 128'(out_valid), 128'(1));
        wait_drain();

        // Whole packet removed exactly, and a packet ending inside a leading segment.
        rx_beats = 0;
        t0       = trunc_seen;
        send_pkt(8, 0, 8, 4'd7, 0);
        send_pkt(6, 0, 8, 4'd8, 0);
        wait_drain();
        check("empty_beats", 128'(rx_beats), 128'(0));
        check("empty_trunc", 128'(trunc_seen - t0), 128'(1));

        // Odd offset/size bits are ignored, then random packets under backpressure.
        rand_ready = 1'b1;
        send_pkt(40, 13, 5, 4'd9, 0);
        for (int p = 0; p < 8; p++) begin
            send_pkt(2 * $urandom_range(1, 40), $urandom_range(0, 64), $urandom_range(0, 8),
                     4'($urandom_range(0, 15)), 0);
        end
        wait_drain();
        rand_ready = 1'b0;
        check("trunc_total", 128'(trunc_seen), 128'(exp_trunc));

        // Reset in the middle of a packet, then a clean packet.
        chk_en = 1'b0;
        send_pkt(64, 12, 4, 4'd10, 3);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_valid", 128'(out_valid), 128'(0));
        check("mid_rst_data", 128'(out_data), 128'(0));
        check("mid_rst_trunc", 128'(trunc_pulse), 128'(0));
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_en   = 1'b1;
        rx_beats = 0;
        send_pkt(64, 12, 4, 4'd11, 0);
        wait_drain();
        check("post_rst_beats", 128'(rx_beats), 128'(8));
        check("post_rst_last_keep", 128'(rx_last_keep), 128'(8'h0F));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
